// File: rtl/serial_byte_collector.sv
// Reassembles an LSB-first serial bit stream into bytes and buffers them in a
// show-ahead FIFO drained over a valid/ready handshake; dropped bytes set a sticky flag.
module serial_byte_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  serial_in,
  input  logic                  bit_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic [2:0]            bit_index,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;

  logic [DATA_WIDTH-1:0] assembled;
  logic                  byte_done;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign assembled  = {serial_in, sr[DATA_WIDTH-1:1]};
  assign byte_done  = bit_valid && (bit_index == 3'd7);
  assign data_valid = (count != '0);
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_count = count;
  assign pop        = data_valid && data_ready;
  // A full FIFO can still take the byte if the head leaves on the same edge.
  assign push       = byte_done && (!fifo_full || pop);
  assign drop       = byte_done && fifo_full && !pop;
  assign data_out   = data_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (clear) begin
      sr        <= '0;
      bit_index <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (bit_valid) begin
        sr        <= assembled;
        bit_index <= bit_index + 3'd1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage carries data only; occupancy is tracked by count, so no reset here.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= assembled;
  end

endmodule

// File: doc/serial_byte_collector.md
Name: serial_byte_collector

Overview:
- Downstream stage of the memory-to-serial path. Consumes the 1-bit stream from the 8:1 mux serializer, which sends each byte LSB first, one bit per clock.
- Reassembles 8-bit bytes and buffers them in a small FIFO.
- Presents buffered bytes to a consumer over a valid/ready handshake.
- Flags dropped bytes with a sticky overflow bit.

Parameters:
- DATA_WIDTH, 8, bits per assembled byte. Serializer width is fixed at 8; other values are unsupported.
- FIFO_DEPTH, 4, number of byte entries. Must be a power of 2.
- ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- clear  input  1  reset, synchronous, active-high.
- serial_in  input  1  serial data bit, LSB of each byte first.
- bit_valid  input  1  serial_in is sampled on an edge only when this is 1.
- data_out  output  DATA_WIDTH  head-of-FIFO byte; 0 when FIFO empty.
- data_valid  output  1  FIFO not empty.
- data_ready  input  1  consumer accepts data_out this cycle.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  output  ADDR_WIDTH+1  number of stored entries, 0..FIFO_DEPTH.
- bit_index  output  3  position of the next bit to be sampled, 0..7.
- overflow  output  1  sticky: a completed byte was dropped.

Behaviour:
- Reset and priority:
  - clear is sampled on the rising edge and has priority over all other activity.
  - Reset values: shift register 0, bit_index 0, read/write pointers 0, fifo_count 0, overflow 0.
  - Resulting outputs: data_valid 0, data_out 0, fifo_full 0.
  - FIFO storage contents need not be cleared.
- Bit collection:
  - On an edge with bit_valid=1: shift register <= {serial_in, sr[7:1]}, and bit_index <= bit_index+1 (mod 8).
  - bit_valid=0: shift register and bit_index hold. Gaps of any length are allowed mid-byte.
- Byte completion:
  - Occurs on an edge with bit_valid=1 and bit_index=7.
  - Assembled byte = {serial_in, sr[7:1]}; it is pushed to the FIFO on that same edge.
  - bit_index wraps to 0.
- Latency: the byte is visible on data_out with data_valid=1 immediately after the completing edge, provided the FIFO was empty.
- FIFO:
  - Show-ahead: data_out is combinational from mem[rd_ptr], gated to 0 when empty.
  - Pop occurs on an edge with data_valid=1 and data_ready=1; rd_ptr increments.
  - data_ready while empty has no effect.
  - Push and pop on the same edge: both happen and fifo_count is unchanged.
  - A push accepted on an edge requires that the FIFO was not full OR a pop occurs on the same edge.
  - A byte pushed into an empty FIFO cannot be popped on the edge it is written.
  - Pointers wrap mod FIFO_DEPTH. Full and empty are distinguished by fifo_count, never by pointer equality alone.
- Overflow:
  - Condition: byte completes while full with no pop on the same edge.
  - The byte is discarded and overflow <= 1, held until clear.
  - FIFO contents and count are unchanged; bit collection continues normally.
- clear mid-byte: the partial byte is discarded, and the next sampled bit becomes bit 0 of a new byte. Byte alignment after clear therefore matches the upstream counters, which also restart on clear.
- No states beyond bit_index and FIFO occupancy; no X may propagate to outputs after the first clear.

Test Plan:
- Reset: hold clear=1 for 2 cycles with serial_in toggling and bit_valid=1 -> data_valid=0, data_out=0x00, fifo_count=0, bit_index=0, overflow=0, fifo_full=0.
- Single byte: data_ready=0; feed bits 0,0,1,1,0,0,1,1 with bit_valid=1 -> after 8th edge data_out=0xCC, data_valid=1, fifo_count=1, bit_index=0.
- Fill and overflow: data_ready=0; feed 0xCC, 0xAA, 0xCC, 0xAA -> fifo_full=1, fifo_count=4. Feed 0x55 -> overflow=1, fifo_count=4, data_out=0xCC. Then data_ready=1 for 4 cycles -> data_out CC, AA, CC, AA, then data_valid=0; overflow stays 1.
- Full with simultaneous pop: FIFO full of CC, AA, CC, AA; data_ready=1 exactly on the edge completing 0x55 -> fifo_count stays 4, overflow=0, tail entry=0x55.
- Gaps and clear mid-byte:
  - Feed 0xAA with bit_valid=0 for 3 cycles after bit 3 -> assembled byte 0xAA, bit_index held at 4 during the gap.
  - Then feed 5 bits, pulse clear, feed 0xAA -> only 0xAA is stored, fifo_count=1.
- Chained with the upstream serializer (memory pattern 0xCC at even addresses, 0xAA at odd), bit_valid=1, data_ready=1, clear released together -> received bytes alternate 0xCC, 0xAA for 16 bytes, then repeat; overflow=0.
